bit_serializer: RTL and testbench

- Parallel-in, serial-out stage that sits directly upstream of the 1100 Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on ser_out; ser_out drives the detector's ip input.
- Supports gapless back-to-back words, so multi-word bit patterns reach the detector without inserted idle bits.

---
 rtl/detector_pkg.sv | 14 +
 rtl/bit_serializer_if.sv | 27 ++
 rtl/bit_serializer.sv | 92 +++++++++
 tb/tb_bit_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/detector_pkg.sv
// Constants shared by the bit serializer and the downstream 1100 sequence detector.
package detector_pkg;

    typedef logic ser_state_t;

    localparam ser_state_t SER_IDLE  = 1'b0;
    localparam ser_state_t SER_SHIFT = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

    // Pattern recognised by the detector fed from ser_out.
    localparam logic [3:0] DET_PATTERN = 4'b1100;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word input and serial bit output of the bit serializer.
interface bit_serializer_if #(
    parameter int WIDTH = detector_pkg::DEFAULT_WIDTH
);

    // Handshake: a word moves when din_valid && din_ready at a posedge; the
    // source holds din/din_valid stable until then, and din_ready never
    // depends on din_valid.
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_done;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, ser_out, ser_valid, frame_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, ser_valid, frame_done, busy
    );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage: one WIDTH-bit word per WIDTH clocks, gapless
// back-to-back when the next word is offered on the last-bit cycle.
module bit_serializer
    import detector_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input logic             clk,
    input logic             reset,
    bit_serializer_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic             ser_out_q, ser_out_next;
    logic             ser_valid_q, ser_valid_next;
    logic             last_bit;
    logic             ready;
    logic             accept;

    // The head of the shift register is always the bit currently on ser_out.
    function automatic logic head_of(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SER_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            ser_out_q <= IDLE_BIT;
            ser_valid_q <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bit_cnt   <= bit_cnt_next;
            ser_out_q <= ser_out_next;
            ser_valid_q <= ser_valid_next;
        end
    end

    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        bit_cnt_next   = bit_cnt;
        ser_out_next   = ser_out_q;
        ser_valid_next = ser_valid_q;
        if (accept) begin
            // Accept only happens in IDLE or on the last bit, so a reload
            // covers both the first word and the gapless follow-on word.
            state_next     = SER_SHIFT;
            shreg_next     = bus.din;
            bit_cnt_next   = '0;
            ser_out_next   = head_of(bus.din);
            ser_valid_next = 1'b1;
        end else if (state == SER_SHIFT) begin
            if (!last_bit) begin
                shreg_next   = shift_once(shreg);
                bit_cnt_next = bit_cnt + CNT_W'(1);
                ser_out_next = head_of(shift_once(shreg));
            end else begin
                state_next     = SER_IDLE;
                shreg_next     = '0;
                bit_cnt_next   = '0;
                ser_out_next   = IDLE_BIT;
                ser_valid_next = 1'b0;
            end
        end
    end

    always_comb begin
        last_bit       = (state == SER_SHIFT) && (bit_cnt == LAST_CNT);
        ready          = (state == SER_IDLE) || last_bit;
        accept         = bus.din_valid && ready;
        bus.din_ready  = ready;
        bus.frame_done = last_bit;
        bus.busy       = (state == SER_SHIFT);
        bus.ser_out    = ser_out_q;
        bus.ser_valid  = ser_valid_q;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: scoreboard on the MSB-first instance,
// hand-checked LSB-first instance, reset and backpressure sequences.
module tb_bit_serializer;
    import detector_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bit_serializer_if #(.WIDTH(W)) bus_m ();
    bit_serializer_if #(.WIDTH(W)) bus_l ();

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset(reset), .bus(bus_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bus(bus_l)
    );

    always #5 clk = ~clk;

    // Scoreboard entries: {expected ser_out, expected frame_done}.
    logic [1:0] exp_q[$];

    int total = 0;
    int bad = 0;
    int frames = 0;
    int hits = 0;
    int bits_seen = 0;
    logic [2:0] hist = '0;

    typedef struct {
        logic [W-1:0] din;
        int           exp_hits;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench model of acceptance: the DUT is ready exactly when no expected
    // bits remain beyond the one currently presented.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset && bus_m.din_valid && exp_q.size() == 0) begin
                for (int i = W - 1; i >= 0; i--)
                    exp_q.push_back({bus_m.din[i], (i == 0) ? 1'b1 : 1'b0});
            end
        end
    end

    // Output monitor: compares every cycle against the scoreboard and runs
    // a 1100 detector model over the valid bits.
    initial begin
        logic [1:0] e;
        logic [3:0] win;
        logic       active;
        forever begin
            @(negedge clk);
            if (!reset) begin
                active = (exp_q.size() != 0);
                check("ser_valid", bus_m.ser_valid, active);
                check("busy", bus_m.busy, active);
                if (active) begin
                    e = exp_q.pop_front();
                    check("ser_out", bus_m.ser_out, e[1]);
                    check("frame_done", bus_m.frame_done, e[0]);
                    bits_seen++;
                    if (e[0]) frames++;
                    win = {hist, bus_m.ser_out};
                    if (win == DET_PATTERN) hits++;
                    hist = win[2:0];
                end else begin
                    check("idle_ser_out", bus_m.ser_out, 1'b0);
                    check("idle_frame_done", bus_m.frame_done, 1'b0);
                    hist = '0;
                end
                check("din_ready", bus_m.din_ready, (exp_q.size() == 0));
            end
        end
    end

    task automatic clear_counts();
        frames = 0;
        hits = 0;
        bits_seen = 0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        @(negedge clk);
        bus_m.din = w;
        bus_m.din_valid = 1'b1;
        @(negedge clk);
        bus_m.din_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] lsb_exp;

        vecs[0] = '{din: 8'hCC, exp_hits: 2};
        vecs[1] = '{din: 8'hC0, exp_hits: 1};
        vecs[2] = '{din: 8'h3C, exp_hits: 1};
        vecs[3] = '{din: 8'hF0, exp_hits: 1};
        vecs[4] = '{din: 8'hAA, exp_hits: 0};
        vecs[5] = '{din: 8'h0C, exp_hits: 1};
        vecs[6] = '{din: 8'hE6, exp_hits: 1};

        bus_m.din = '0;
        bus_m.din_valid = 1'b0;
        bus_l.din = '0;
        bus_l.din_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ser_out", bus_m.ser_out, 1'b0);
        check("rst_ser_valid", bus_m.ser_valid, 1'b0);
        check("rst_din_ready", bus_m.din_ready, 1'b1);
        check("rst_busy", bus_m.busy, 1'b0);
        check("rst_frame_done", bus_m.frame_done, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Idle for 5 cycles; the monitor checks each one
        repeat (5) @(negedge clk);

        // Single words from the table
        for (int v = 0; v < 7; v++) begin
            clear_counts();
            send_word(vecs[v].din);
            repeat (W + 2) @(negedge clk);
            #1;
            check("word_frames", frames, 1);
            check("word_bits", bits_seen, W);
            check("word_hits", hits, vecs[v].exp_hits);
            check("word_drained", exp_q.size(), 0);
        end

        // Back-to-back with backpressure: changing din on bits 1-7 is ignored
        clear_counts();
        @(negedge clk);
        bus_m.din = 8'hC0;
        bus_m.din_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus_m.din = W'($urandom_range(0, 255));
        end
        @(negedge clk);
        bus_m.din = 8'h3C;
        @(negedge clk);
        bus_m.din_valid = 1'b0;
        bus_m.din = W'($urandom_range(0, 255));
        repeat (10) @(negedge clk);
        #1;
        check("b2b_frames", frames, 2);
        check("b2b_bits", bits_seen, 2 * W);
        check("b2b_hits", hits, 2);

        // Constant din with valid held high gives a periodic stream
        clear_counts();
        @(negedge clk);
        bus_m.din = 8'h9C;
        bus_m.din_valid = 1'b1;
        repeat (17) @(negedge clk);
        bus_m.din_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("stream_frames", frames, 3);
        check("stream_bits", bits_seen, 3 * W);
        check("stream_hits", hits, 3);

        // Reset during bit 3 of 8'hFF
        send_word(8'hFF);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        clear_counts();
        #1;
        check("mid_rst_ser_out", bus_m.ser_out, 1'b0);
        check("mid_rst_ser_valid", bus_m.ser_valid, 1'b0);
        check("mid_rst_busy", bus_m.busy, 1'b0);
        check("mid_rst_din_ready", bus_m.din_ready, 1'b1);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("no_resume_bits", bits_seen, 0);
        check("post_rst_din_ready", bus_m.din_ready, 1'b1);

        // LSB-first instance
        lsb_exp = 8'b0011_0000;
        @(negedge clk);
        bus_l.din = 8'h0C;
        bus_l.din_valid = 1'b1;
        @(negedge clk);
        bus_l.din_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (k != 0) @(negedge clk);
            check("lsb_ser_valid", bus_l.ser_valid, 1'b1);
            check("lsb_ser_out", bus_l.ser_out, lsb_exp[W-1-k]);
            check("lsb_frame_done", bus_l.frame_done, (k == W - 1) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        check("lsb_after_valid", bus_l.ser_valid, 1'b0);
        check("lsb_after_ser_out", bus_l.ser_out, 1'b0);
        check("lsb_after_ready", bus_l.din_ready, 1'b1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
